fifo_stream_drain: RTL and testbench

- Sits directly downstream of the team's synchronous 16-entry FIFO.
- Issues the FIFO read strobe and absorbs the FIFO's one-cycle registered read latency.
- Presents the words as a valid/ready stream with full throughput (1 word/cycle) for the next pipeline stage.
- Provides a synchronous flush and a delivered-word counter.

---
 rtl/fifo_stream_drain.sv | 82 ++++++++
 tb/tb_fifo_stream_drain.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain.sv
// Drains a synchronous FIFO with one-cycle registered read data into a valid/ready stream.
// A 2-entry skid buffer hides the read latency so the stream can move one word per cycle.
module fifo_stream_drain #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty_i,
    output logic              fifo_re_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  word_cnt_o
);

    logic [1:0]        count;
    logic              rd_pending;
    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;
    logic [DATA_W-1:0] entry0_nxt;
    logic [DATA_W-1:0] entry1_nxt;
    logic [CNT_W-1:0]  word_cnt;
    logic              pop;
    logic [1:0]        after_pop;
    logic [1:0]        occupancy;

    assign pop         = out_valid_o & out_ready_i;
    assign after_pop   = count - {1'b0, pop};
    // Words buffered or in flight once this cycle's pop and capture settle; never exceeds 2.
    assign occupancy   = after_pop + {1'b0, rd_pending};

    assign fifo_re_o   = rst_n & ~fifo_empty_i & ~flush_i & (occupancy < 2'd2);
    assign out_valid_o = (count != 2'd0);
    assign out_data_o  = entry0;
    assign word_cnt_o  = word_cnt;

    always_comb begin
        entry0_nxt = entry0;
        entry1_nxt = entry1;
        if (pop) begin
            entry0_nxt = entry1;
        end
        // The returning word lands behind whatever survives this cycle's pop.
        if (rd_pending) begin
            if (after_pop == 2'd0) begin
                entry0_nxt = fifo_data_i;
            end else begin
                entry1_nxt = fifo_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            rd_pending <= 1'b0;
            entry0     <= '0;
            entry1     <= '0;
            word_cnt   <= '0;
        end else begin
            word_cnt <= word_cnt + {{(CNT_W-1){1'b0}}, pop};
            if (flush_i) begin
                count      <= 2'd0;
                rd_pending <= 1'b0;
            end else begin
                count      <= occupancy;
                rd_pending <= fifo_re_o;
                entry0     <= entry0_nxt;
                entry1     <= entry1_nxt;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        (rd_pending && !flush_i) |-> (count != 2'd2 || pop));
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: a queue-based FIFO feeds two DUTs (CNT_W 16 and 4),
// a word-level model predicts the stream every cycle, and directed phases pin the model.
module tb_fifo_stream_drain;

    typedef struct {
        logic [31:0] d;
        int          c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_re, fifo_re4;
    logic [31:0] fifo_data = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_valid4;
    logic        out_ready = 1'b0;
    logic [31:0] out_data, out_data4;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt4;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;

    logic [31:0] fq[$];
    ent_t        exp_q[$];
    ent_t        dlog[$];
    int          rlog[$];
    int          cyc = 0;
    int          exp_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    fifo_stream_drain #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty_i(fifo_empty), .fifo_re_o(fifo_re),
        .fifo_data_i(fifo_data), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .word_cnt_o(word_cnt)
    );

    fifo_stream_drain #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .fifo_empty_i(fifo_empty), .fifo_re_o(fifo_re4),
        .fifo_data_i(fifo_data), .flush_i(flush), .out_valid_o(out_valid4),
        .out_ready_i(out_ready), .out_data_o(out_data4), .word_cnt_o(word_cnt4)
    );

    always #5 clk = ~clk;

    // Upstream FIFO: registered read data, empty flag updated on the edge; ignores rst_n.
    always @(posedge clk) begin
        logic [31:0] t;
        if (fifo_re) begin
            t = (fq.size() > 0) ? fq.pop_front() : 32'hDEAD_BEEF;
            fifo_data <= t;
        end
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Word-level model: each word read in cycle N is deliverable from cycle N+2 onward.
    always @(negedge clk) begin
        bit ev, p, er;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            cyc++;
            ev = (exp_q.size() > 0) && (cyc - exp_q[0].c >= 2);
            chk("out_valid", out_valid, ev);
            chk("out_valid_w4", out_valid4, ev);
            if (ev) chk("out_data", out_data, exp_q[0].d);
            chk("word_cnt", word_cnt, exp_cnt[15:0]);
            chk("word_cnt_w4", word_cnt4, exp_cnt[3:0]);
            p  = ev && out_ready;
            er = !fifo_empty && !flush && (exp_q.size() - int'(p) < 2);
            chk("fifo_re", fifo_re, er);
            chk("fifo_re_w4", fifo_re4, er);
            if (p) begin
                dlog.push_back('{exp_q[0].d, cyc});
                void'(exp_q.pop_front());
                exp_cnt++;
            end
            if (flush) exp_q.delete();
            if (er && fq.size() > 0) begin
                exp_q.push_back('{fq[0], cyc});
                rlog.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input logic [3:0] exp4, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (int'(word_cnt) == target) begin
                hit = 1'b1;
                break;
            end
        end
        if (hit) begin
            chk(nm, word_cnt4, exp4);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout, word_cnt=%0d required %0d", nm, word_cnt, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_re", fifo_re, 0);
        chk("rst_cnt", word_cnt, 0);
        chk("rst_data", out_data, 0);
        tick(2);
        rst_n = 1'b1;
        tick();

        // Back-to-back: preload 16 words under flush, then stream
        flush = 1'b1;
        for (int i = 0; i < 16; i++) wr(32'h10 + i);
        tick();
        rlog.delete();
        dlog.delete();
        flush     = 1'b0;
        out_ready = 1'b1;
        tick(25);
        chk("b2b_reads", rlog.size(), 16);
        if (rlog.size() == 16) chk("b2b_read_span", rlog[15] - rlog[0], 15);
        chk("b2b_words", dlog.size(), 16);
        for (int i = 0; i < dlog.size(); i++) chk("b2b_data", dlog[i].d, 32'h10 + i);
        if (dlog.size() == 16 && rlog.size() > 0) begin
            chk("b2b_latency", dlog[0].c - rlog[0], 2);
            chk("b2b_out_span", dlog[15].c - dlog[0].c, 15);
        end
        chk("b2b_cnt", word_cnt, 16);

        // Backpressure: only two reads while stalled, head word held
        out_ready = 1'b0;
        rlog.delete();
        for (int i = 0; i < 8; i++) wr(32'h20 + i);
        tick(6);
        chk("bp_reads", rlog.size(), 2);
        chk("bp_valid", out_valid, 1);
        chk("bp_hold", out_data, 32'h20);
        dlog.delete();
        out_ready = 1'b1;
        tick(15);
        chk("bp_words", dlog.size(), 8);
        for (int i = 0; i < dlog.size(); i++) chk("bp_data", dlog[i].d, 32'h20 + i);
        if (dlog.size() == 8) chk("bp_no_gap", dlog[7].c - dlog[0].c, 7);
        chk("bp_cnt", word_cnt, 24);

        // Trickle: one word every 5 cycles
        rlog.delete();
        dlog.delete();
        for (int k = 0; k < 4; k++) begin
            wr(32'h30 + k);
            tick(4);
        end
        tick(3);
        chk("tr_reads", rlog.size(), 4);
        chk("tr_words", dlog.size(), 4);
        for (int i = 0; i < dlog.size() && i < rlog.size(); i++) begin
            chk("tr_latency", dlog[i].c - rlog[i], 2);
            chk("tr_data", dlog[i].d, 32'h30 + i);
        end

        // Flush with one buffered word and one read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(32'h40 + i);
        tick(5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        dlog.delete();
        out_ready = 1'b1;
        tick(8);
        chk("fl_words", dlog.size(), 2);
        if (dlog.size() == 2) begin
            chk("fl_next0", dlog[0].d, 32'h43);
            chk("fl_next1", dlog[1].d, 32'h44);
        end

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) wr(32'h50 + i);
        tick(2);
        out_ready = 1'b1;
        tick(2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_re", fifo_re, 0);
        chk("ar_cnt", word_cnt, 0);
        chk("ar_cnt_w4", word_cnt4, 0);
        tick(2);
        rst_n = 1'b1;
        dlog.delete();
        tick(8);
        chk("ar_words", dlog.size(), 2);
        if (dlog.size() == 2) begin
            chk("ar_head0", dlog[0].d, 32'h54);
            chk("ar_head1", dlog[1].d, 32'h55);
        end
        chk("ar_cnt_after", word_cnt, 2);

        // Counter wrap on the 4-bit instance
        #1;
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) wr(32'h60 + i);
        out_ready = 1'b1;
        wait_cnt(15, 4'd15, "wrap_15");
        wait_cnt(16, 4'd0, "wrap_0");
        wait_cnt(17, 4'd1, "wrap_1");
        tick(4);
        chk("wrap_total", word_cnt, 17);
        chk("wrap_total_w4", word_cnt4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
